// File: rtl/nios_debug_vji_pkg.sv
// Shared types and constants for the Nios II debug virtual-JTAG master.
// Contents: scan FSM state enum, debug-slave IR codes, default DR length.
package nios_debug_vji_pkg;

    localparam int unsigned DEFAULT_DR_WIDTH = 38;
    localparam int unsigned DEFAULT_IR_WIDTH = 2;

    // Virtual IR codes understood by the Nios II debug slave
    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACECTRL = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACEMEM  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RTI,
        ST_RESP
    } vji_state_e;

endpackage

// File: rtl/nios_debug_vji_tck_gen.sv
// Test-clock generator: tck is low for TCK_DIV clk, then high for TCK_DIV clk.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   enable          run tck; when low, tck is held low and the low phase restarts
//   tck             generated test clock (registered)
//   tck_rise_pre_c  pulse in the last low-phase cycle (tck rises at the next edge)
//   tck_fall_c      pulse in the last high-phase cycle (tck falls at the next edge)
module nios_debug_vji_tck_gen #(
    parameter int unsigned TCK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tck,
    output logic tck_rise_pre_c,
    output logic tck_fall_c
);

    localparam int unsigned CNT_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TCK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             phase_end_c;

    assign phase_end_c    = enable && (cnt == CNT_LAST);
    assign tck_rise_pre_c = phase_end_c && !tck;
    assign tck_fall_c     = phase_end_c && tck;

    // Half-period counter; toggles tck at the end of each phase
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            tck <= ~tck;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/nios_debug_vji_master.sv
// Initiator end of the Nios II debug-slave virtual-JTAG interface.
// One command = one IR update plus one DR_WIDTH-bit DR scan; captured tdo bits
// are returned on the response channel.
// Ports:
//   clk, reset                          system clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_ir/cmd_dr   scan request (DR shifted LSB first)
//   rsp_valid/rsp_ready/rsp_dr/rsp_ir_out  scan result, held until accepted
//   vji_tck/vji_tdi/vji_tdo             serial test clock and data
//   vji_ir_in/vji_ir_out                virtual IR to / status from target
//   vji_uir/cdr/sdr/udr/rti             one-hot virtual TAP state strobes
// Config macro: VJI_MASTER_IR_CACHE_EN -- skip UIR when cmd_ir matches the
// IR of the last completed scan.
module nios_debug_vji_master
    import nios_debug_vji_pkg::*;
#(
    parameter int unsigned DR_WIDTH = DEFAULT_DR_WIDTH,
    parameter int unsigned IR_WIDTH = DEFAULT_IR_WIDTH,
    parameter int unsigned TCK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int unsigned CNT_W = $clog2(DR_WIDTH + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DR_WIDTH - 1);

    vji_state_e          state;
    logic [DR_WIDTH-1:0] dr_q;
    logic [CNT_W-1:0]    bit_cnt;
    logic                tck_en_c;
    logic                rise_pre_c;
    logic                fall_c;
    logic                skip_uir_c;

    assign tck_en_c = state inside {ST_UIR, ST_CDR, ST_SDR, ST_UDR, ST_RTI};

    nios_debug_vji_tck_gen #(
        .TCK_DIV(TCK_DIV)
    ) u_tck_gen (
        .clk           (clk),
        .reset         (reset),
        .enable        (tck_en_c),
        .tck           (vji_tck),
        .tck_rise_pre_c(rise_pre_c),
        .tck_fall_c    (fall_c)
    );

`ifdef VJI_MASTER_IR_CACHE_EN
    logic [IR_WIDTH-1:0] ir_cache;
    logic                ir_cache_vld;

    // Remember the IR of the last scan that ran to completion
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_cache     <= '0;
            ir_cache_vld <= 1'b0;
        end else if (state == ST_RTI && fall_c) begin
            ir_cache     <= vji_ir_in;
            ir_cache_vld <= 1'b1;
        end
    end

    assign skip_uir_c = ir_cache_vld && (cmd_ir == ir_cache);
`else
    assign skip_uir_c = 1'b0;
`endif

    // Scan sequencer; every state change lands on a tck period boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_dr     <= '0;
            rsp_ir_out <= '0;
            vji_tdi    <= 1'b0;
            vji_ir_in  <= '0;
            vji_uir    <= 1'b0;
            vji_cdr    <= 1'b0;
            vji_sdr    <= 1'b0;
            vji_udr    <= 1'b0;
            vji_rti    <= 1'b0;
            dr_q       <= '0;
            bit_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        vji_ir_in <= cmd_ir;
                        dr_q      <= cmd_dr;
                        bit_cnt   <= '0;
                        if (skip_uir_c) begin
                            state   <= ST_CDR;
                            vji_cdr <= 1'b1;
                        end else begin
                            state   <= ST_UIR;
                            vji_uir <= 1'b1;
                        end
                    end
                end
                ST_UIR: begin
                    if (fall_c) begin
                        state   <= ST_CDR;
                        vji_uir <= 1'b0;
                        vji_cdr <= 1'b1;
                    end
                end
                ST_CDR: begin
                    if (fall_c) begin
                        state   <= ST_SDR;
                        vji_cdr <= 1'b0;
                        vji_sdr <= 1'b1;
                        vji_tdi <= dr_q[0];
                        dr_q    <= dr_q >> 1;
                    end
                end
                ST_SDR: begin
                    // Capture fills from the top so bit k ends up at rsp_dr[k]
                    if (rise_pre_c) begin
                        rsp_dr <= (rsp_dr >> 1) | (DR_WIDTH'(vji_tdo) << (DR_WIDTH - 1));
                    end
                    if (fall_c) begin
                        if (bit_cnt == BIT_LAST) begin
                            state   <= ST_UDR;
                            vji_sdr <= 1'b0;
                            vji_tdi <= 1'b0;
                            vji_udr <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            vji_tdi <= dr_q[0];
                            dr_q    <= dr_q >> 1;
                        end
                    end
                end
                ST_UDR: begin
                    if (rise_pre_c) begin
                        rsp_ir_out <= vji_ir_out;
                    end
                    if (fall_c) begin
                        state   <= ST_RTI;
                        vji_udr <= 1'b0;
                        vji_rti <= 1'b1;
                    end
                end
                ST_RTI: begin
                    if (fall_c) begin
                        state     <= ST_RESP;
                        vji_rti   <= 1'b0;
                        rsp_valid <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios_debug_vji_master.sv
// Bench for nios_debug_vji_master: a shift-register target model, a
// period-level reference model of the scan timeline, and a small
// DR_WIDTH=1 / TCK_DIV=1 instance with directed checks.
module tb_nios_debug_vji_master;

    localparam int DRW = 38;
    localparam int T   = 4;
    localparam int P   = 2 * T;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- main instance ----------------
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [1:0]      cmd_ir = '0;
    logic [DRW-1:0]  cmd_dr = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [DRW-1:0]  rsp_dr;
    logic [1:0]      rsp_ir_out;
    logic            vji_tck, vji_tdi, vji_tdo;
    logic [1:0]      vji_ir_in;
    logic [1:0]      vji_ir_out = '0;
    logic            vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    nios_debug_vji_master #(.DR_WIDTH(DRW), .IR_WIDTH(2), .TCK_DIV(T)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
    );

    // Target: DR loaded with cap_val in CDR, shifted toward bit 0 in SDR
    logic [DRW-1:0] tgt_sr = '0;
    logic [DRW-1:0] cap_val = '0;
    always @(posedge vji_tck) begin
        if (vji_cdr)      tgt_sr <= cap_val;
        else if (vji_sdr) tgt_sr <= {vji_tdi, tgt_sr[DRW-1:1]};
    end
    assign vji_tdo = tgt_sr[0];

    // ---------------- reference model ----------------
    // m_state: 0 idle, 1 scanning, 2 response pending
    int             m_state = 0;
    int             m_start = 0;
    int             m_skip  = 0;
    logic [DRW-1:0] m_dr = '0, m_cap = '0;
    logic [1:0]     m_ir_in = '0, m_irout = '0, m_cache = '0;
    bit             m_cache_vld = 0, model_on = 0, post_rst = 0, resp_first = 0;
    int             acc_cyc = 0, last_lat = 0;
    int             n_uir = 0, n_cdr = 0, n_udr = 0, n_rti = 0, n_sdr_rise = 0;
    logic           prev_tck = 1'b0, prev_rv = 1'b0;

    always @(negedge clk) begin
        int j, p, ph, nper;
        logic [10:0] e, a;
        a = {cmd_ready, rsp_valid, vji_tck, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tdi, vji_ir_in};
        if (model_on) begin
            if (vji_uir) n_uir++;
            if (vji_cdr) n_cdr++;
            if (vji_udr) n_udr++;
            if (vji_rti) n_rti++;
            if (vji_sdr && vji_tck && !prev_tck) n_sdr_rise++;
            if (rsp_valid && !prev_rv) last_lat = cyc - acc_cyc;

            e = '0;
            e[1:0] = m_ir_in;
            case (m_state)
                0: e[10] = 1'b1;
                1: begin
                    j  = cyc - m_start;
                    p  = j / P + m_skip;
                    ph = j % P;
                    e[8] = (ph >= T);
                    e[7] = (p == 0);
                    e[6] = (p == 1);
                    e[5] = (p >= 2 && p <= DRW + 1);
                    e[4] = (p == DRW + 2);
                    e[3] = (p == DRW + 3);
                    if (e[5]) e[2] = m_dr[p-2];
                end
                default: begin
                    e[9] = 1'b1;
                    chk("rsp_dr", 64'(rsp_dr), 64'(m_cap));
                    chk("rsp_ir_out", 64'(rsp_ir_out), 64'(m_irout));
                end
            endcase
            chk("pins", 64'(a), 64'(e));
            if (post_rst) begin
                chk("rst_rsp_dr", 64'(rsp_dr), 64'd0);
                chk("rst_rsp_ir_out", 64'(rsp_ir_out), 64'd0);
                post_rst = 0;
            end
            if (resp_first) begin
                chk("target_dr", 64'(tgt_sr), 64'(m_dr));
                resp_first = 0;
            end
        end
        prev_tck = vji_tck;
        prev_rv  = rsp_valid;

        // advance the model to the next cycle
        if (reset) begin
            m_state = 0; m_ir_in = '0; m_cache_vld = 0; post_rst = 1; model_on = 1;
        end else if (model_on) begin
            case (m_state)
                0: if (cmd_valid) begin
                    m_state = 1; m_start = cyc + 1; acc_cyc = cyc;
`ifdef VJI_MASTER_IR_CACHE_EN
                    m_skip = (m_cache_vld && cmd_ir == m_cache) ? 1 : 0;
`else
                    m_skip = 0;
`endif
                    m_dr = cmd_dr; m_ir_in = cmd_ir; m_cap = cap_val; m_irout = vji_ir_out;
                    n_uir = 0; n_cdr = 0; n_udr = 0; n_rti = 0; n_sdr_rise = 0;
                end
                1: begin
                    nper = DRW + 4 - m_skip;
                    if (cyc - m_start == nper * P - 1) begin
                        m_state = 2; m_cache = m_ir_in; m_cache_vld = 1; resp_first = 1;
                    end
                end
                default: if (rsp_ready) m_state = 0;
            endcase
        end
    end

    // ---------------- small instance: DR_WIDTH=1, TCK_DIV=1 ----------------
    logic       s_cmd_valid = 1'b0, s_cmd_ready;
    logic [1:0] s_cmd_ir = '0;
    logic [0:0] s_cmd_dr = '0;
    logic       s_rsp_valid, s_rsp_ready = 1'b0;
    logic [0:0] s_rsp_dr;
    logic [1:0] s_rsp_ir_out, s_ir_in;
    logic [1:0] s_ir_out = 2'b10;
    logic       s_tck, s_tdi, s_tdo, s_uir, s_cdr, s_sdr, s_udr, s_rti;
    logic       s_sr = 1'b1;

    nios_debug_vji_master #(.DR_WIDTH(1), .IR_WIDTH(2), .TCK_DIV(1)) dut1 (
        .clk(clk), .reset(reset),
        .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_ir(s_cmd_ir), .cmd_dr(s_cmd_dr),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_dr(s_rsp_dr), .rsp_ir_out(s_rsp_ir_out),
        .vji_tck(s_tck), .vji_tdi(s_tdi), .vji_tdo(s_tdo),
        .vji_ir_in(s_ir_in), .vji_ir_out(s_ir_out),
        .vji_uir(s_uir), .vji_cdr(s_cdr), .vji_sdr(s_sdr), .vji_udr(s_udr), .vji_rti(s_rti)
    );

    always @(posedge s_tck) begin
        if (s_cdr)      s_sr <= 1'b0;
        else if (s_sdr) s_sr <= s_tdi;
    end
    assign s_tdo = s_sr;

    // ---------------- stimulus ----------------
    function automatic logic [DRW-1:0] rand_dr();
        return DRW'({$urandom(), $urandom()});
    endfunction

    task automatic start_scan(input logic [1:0] ir, input logic [DRW-1:0] dr,
                              input logic [DRW-1:0] cap, input logic [1:0] irout);
        int w = 0;
        while (m_state != 0 && w < 2000) begin @(posedge clk); #1; w++; end
        chk("cmd_ready_before_scan", 64'(cmd_ready), 64'd1);
        cap_val = cap; vji_ir_out = irout;
        cmd_ir = ir; cmd_dr = dr; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_ir = 2'($urandom()); cmd_dr = rand_dr();
    endtask

    task automatic wait_rv();
        int w = 0;
        while (!rsp_valid && w < 2000) begin @(posedge clk); #1; w++; end
        chk("rsp_valid_arrives", 64'(rsp_valid), 64'd1);
        @(negedge clk); #1;
    endtask

    task automatic release_rsp(input int hold);
        repeat (hold) @(posedge clk);
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DRW-1:0] d, c;
        logic [1:0]     ir;
        int             w, acc;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_tap_pins", 64'({vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'd0);
        chk("reset_ir_in", 64'(vji_ir_in), 64'd0);
        chk("reset_rsp_dr", 64'(rsp_dr), 64'd0);

        // basic scan with 20 cycles of response backpressure
        start_scan(2'd2, 38'h15_1234_5678, 38'h2A_DEAD_BEEF, 2'b01);
        wait_rv();
        chk("basic_rsp_dr", 64'(rsp_dr), 64'h2A_DEAD_BEEF);
        chk("basic_rsp_ir_out", 64'(rsp_ir_out), 64'd1);
        chk("basic_latency", 64'(last_lat), 64'd337);
        chk("basic_uir_cycles", 64'(n_uir), 64'd8);
        chk("basic_cdr_cycles", 64'(n_cdr), 64'd8);
        chk("basic_udr_cycles", 64'(n_udr), 64'd8);
        chk("basic_rti_cycles", 64'(n_rti), 64'd8);
        chk("basic_sdr_periods", 64'(n_sdr_rise), 64'd38);
        chk("basic_target_dr", 64'(tgt_sr), 64'h15_1234_5678);
        repeat (20) @(posedge clk);
        #1;
        chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("bp_rsp_dr", 64'(rsp_dr), 64'h2A_DEAD_BEEF);
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        chk("bp_cmd_ready_after", 64'(cmd_ready), 64'd1);

        // back-to-back scan with the same IR
        start_scan(2'd2, rand_dr(), rand_dr(), 2'b10);
        wait_rv();
`ifdef VJI_MASTER_IR_CACHE_EN
        chk("b2b_latency", 64'(last_lat), 64'd329);
        chk("b2b_uir_cycles", 64'(n_uir), 64'd0);
`else
        chk("b2b_latency", 64'(last_lat), 64'd337);
        chk("b2b_uir_cycles", 64'(n_uir), 64'd8);
`endif
        release_rsp(0);

        // reset in the middle of SDR bit 17
        start_scan(2'd1, rand_dr(), rand_dr(), 2'b11);
        w = 0;
        while (!(m_state == 1 && (cyc - m_start) / P + m_skip == 19) && w < 1000) begin
            @(posedge clk); #1; w++;
        end
        chk("reached_bit17", 64'(vji_sdr), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("midrst_pins", 64'({cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}),
            64'h100);
        chk("midrst_ir_in", 64'(vji_ir_in), 64'd0);
        chk("midrst_rsp_dr", 64'(rsp_dr), 64'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);

        // following scan completes normally, cache was invalidated
        c = 38'h0A_5A5A_C3C3;
        start_scan(2'd1, 38'h3C_0F0F_F0F0, c, 2'b10);
        wait_rv();
        chk("postrst_rsp_dr", 64'(rsp_dr), 64'h0A_5A5A_C3C3);
        chk("postrst_latency", 64'(last_lat), 64'd337);
        chk("postrst_uir_cycles", 64'(n_uir), 64'd8);
        release_rsp(1);

        // randomized scans, some repeating the previous IR
        ir = 2'd1;
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 0) ir = 2'($urandom());
            d = rand_dr();
            c = rand_dr();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            start_scan(ir, d, c, 2'($urandom()));
            wait_rv();
            release_rsp($urandom_range(0, 6));
        end

        // DR_WIDTH=1, TCK_DIV=1 instance
        @(posedge clk); #1;
        chk("s_cmd_ready", 64'(s_cmd_ready), 64'd1);
        s_cmd_valid = 1'b1; s_cmd_dr = 1'b1; s_cmd_ir = 2'd3;
        acc = cyc;
        @(posedge clk); #1 s_cmd_valid = 1'b0; s_cmd_dr = 1'b0;
        w = 0;
        while (!s_rsp_valid && w < 100) begin @(posedge clk); #1; w++; end
        chk("s_latency", 64'(cyc - acc), 64'd11);
        chk("s_rsp_dr", 64'(s_rsp_dr), 64'd0);
        chk("s_target_captured", 64'(s_sr), 64'd1);
        chk("s_rsp_ir_out", 64'(s_rsp_ir_out), 64'd2);
        s_rsp_ready = 1'b1;
        @(posedge clk); #1 s_rsp_ready = 1'b0;
        chk("s_cmd_ready_after", 64'(s_cmd_ready), 64'd1);

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
